// File: rtl/niosmp_pio_pkg.sv
//==============================================================================
// Module : niosmp_pio_pkg
// Brief  : Shared register-map and status-bit constants for the niosmp PIO.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

package niosmp_pio_pkg;

   localparam logic [2:0] ADDR_DATA    = 3'd0;
   localparam logic [2:0] ADDR_LEN     = 3'd1;
   localparam logic [2:0] ADDR_STATUS  = 3'd2;
   localparam logic [2:0] ADDR_IRQMASK = 3'd3;
   localparam logic [2:0] ADDR_SET     = 3'd4;
   localparam logic [2:0] ADDR_CLR     = 3'd5;
   localparam logic [2:0] ADDR_PULSE   = 3'd6;

   localparam int ST_BUSY = 0;
   localparam int ST_OVR  = 1;
   localparam int ST_DONE = 2;

   function automatic logic [31:0] status_word(input logic busy,
                                               input logic ovr,
                                               input logic done);
      logic [31:0] w;
      w          = '0;
      w[ST_BUSY] = busy;
      w[ST_OVR]  = ovr;
      w[ST_DONE] = done;
      return w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/niosmp_pio_out_pulse_if.sv
//==============================================================================
// Module : niosmp_pio_out_pulse_if
// Brief  : Avalon-MM slave bus bundle for the niosmp pulse PIO.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface niosmp_pio_out_pulse_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        read_n;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (output address, chipselect, read_n, write_n, writedata,
                   input  readdata);
   modport slave  (input  address, chipselect, read_n, write_n, writedata,
                   output readdata);
endinterface

`default_nettype wire

// File: rtl/niosmp_pio_pulse_timer.sv
//==============================================================================
// Module : niosmp_pio_pulse_timer
// Brief  : One-shot pulse length register and down-counter with done/overrun.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module niosmp_pio_pulse_timer #(
   parameter int PULSE_W = 16
) (
   input  wire logic               clk,
   input  wire logic               reset,
   input  wire logic               len_wr,
   input  wire logic [PULSE_W-1:0] len_wd,
   input  wire logic               pulse_wr,
   output logic [PULSE_W-1:0]      len_q,
   output logic                    busy,
   output logic                    start,
   output logic                    done,
   output logic                    overrun_set
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]         state_q;
   logic [0:0]         state_d;
   logic [PULSE_W-1:0] cnt_q;
   logic               last;

   assign last = (cnt_q == PULSE_W'(1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (pulse_wr && (len_q != '0)) state_d = S_RUN;
         S_RUN:  if (last) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy        = (state_q == S_RUN);
      start       = pulse_wr && !busy && (len_q != '0);
      done        = busy && last;
      overrun_set = pulse_wr && busy;
   end

   // The final decrement lands on zero, so cnt_q needs no separate clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (start) begin
         cnt_q <= len_q;
      end else if (busy) begin
         cnt_q <= cnt_q - PULSE_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len_q <= '0;
      end else if (len_wr) begin
         len_q <= len_wd;
      end
   end

endmodule

`default_nettype wire

// File: rtl/niosmp_pio_out_pulse.sv
//==============================================================================
// Module : niosmp_pio_out_pulse
// Brief  : Avalon-MM output PIO with set/clear and one-shot pulse engine.
//          Optional pulse-done interrupt: NIOSMP_PIO_PULSE_IRQ_EN.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module niosmp_pio_out_pulse
   import niosmp_pio_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter int               PULSE_W     = 16,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  wire logic               clk,
   input  wire logic               reset,
   niosmp_pio_out_pulse_if.slave   bus,
   output logic [WIDTH-1:0]        out_port,
   output logic                    irq
);

   logic               wr;
   logic               rd;
   logic [WIDTH-1:0]   wd;
   logic [WIDTH-1:0]   data_q;
   logic [WIDTH-1:0]   mask_q;
   logic [PULSE_W-1:0] len_q;
   logic               busy;
   logic               start;
   logic               done;
   logic               overrun_set;
   logic               overrun_q;
   logic               done_pending_q;
   logic               irq_mask_q;
   logic [31:0]        rdata;
   logic               unused_wd;

   assign wr        = bus.chipselect & ~bus.write_n;
   assign rd        = bus.chipselect & ~bus.read_n;
   assign wd        = bus.writedata[WIDTH-1:0];
   assign unused_wd = ^bus.writedata;

   niosmp_pio_pulse_timer #(
      .PULSE_W (PULSE_W)
   ) u_timer (
      .clk         (clk),
      .reset       (reset),
      .len_wr      (wr && (bus.address == ADDR_LEN)),
      .len_wd      (bus.writedata[PULSE_W-1:0]),
      .pulse_wr    (wr && (bus.address == ADDR_PULSE)),
      .len_q       (len_q),
      .busy        (busy),
      .start       (start),
      .done        (done),
      .overrun_set (overrun_set)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q <= RESET_VALUE;
      end else if (wr) begin
         case (bus.address)
            ADDR_DATA: data_q <= wd;
            ADDR_SET:  data_q <= data_q | wd;
            ADDR_CLR:  data_q <= data_q & ~wd;
            default:   data_q <= data_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mask_q <= '0;
      end else if (start) begin
         mask_q <= wd;
      end
   end

   // Hardware set events take priority over software clears.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overrun_q      <= 1'b0;
         done_pending_q <= 1'b0;
      end else begin
         if (overrun_set) begin
            overrun_q <= 1'b1;
         end else if (wr && (bus.address == ADDR_STATUS) && bus.writedata[ST_OVR]) begin
            overrun_q <= 1'b0;
         end
         if (done) begin
            done_pending_q <= 1'b1;
         end else if (wr && (bus.address == ADDR_STATUS) && bus.writedata[ST_DONE]) begin
            done_pending_q <= 1'b0;
         end
      end
   end

`ifdef NIOSMP_PIO_PULSE_IRQ_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_mask_q <= 1'b0;
      end else if (wr && (bus.address == ADDR_IRQMASK)) begin
         irq_mask_q <= bus.writedata[0];
      end
   end
   assign irq = done_pending_q & irq_mask_q;
`else
   assign irq_mask_q = 1'b0;
   assign irq        = 1'b0;
`endif

   always_comb begin
      rdata = '0;
      case (bus.address)
         ADDR_DATA:    rdata = 32'(data_q);
         ADDR_LEN:     rdata = 32'(len_q);
         ADDR_STATUS:  rdata = status_word(busy, overrun_q, done_pending_q);
         ADDR_IRQMASK: rdata = 32'(irq_mask_q);
         default:      rdata = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.readdata <= '0;
      end else if (rd) begin
         bus.readdata <= rdata;
      end
   end

   assign out_port = data_q ^ (busy ? mask_q : '0);

endmodule

`default_nettype wire

// File: tb/tb_niosmp_pio_out_pulse.sv
//==============================================================================
// Module : tb_niosmp_pio_out_pulse
// Brief  : Directed self-checking bench for the niosmp pulse PIO.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_niosmp_pio_out_pulse;
   import niosmp_pio_pkg::*;

   logic       clk;
   logic       reset;
   logic [7:0] out_port;
   logic       irq;
   logic [31:0] rv;
   int         n_assert;
   int         n_fail;

   niosmp_pio_out_pulse_if bus_if ();

   niosmp_pio_out_pulse #(
      .WIDTH       (8),
      .PULSE_W     (16),
      .RESET_VALUE (8'hA5)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus_if),
      .out_port (out_port),
      .irq      (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Tasks are entered on a falling edge and return on the next one.
   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      bus_if.address    = a;
      bus_if.writedata  = d;
      bus_if.chipselect = 1'b1;
      bus_if.write_n    = 1'b0;
      @(negedge clk);
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      bus_if.address    = a;
      bus_if.chipselect = 1'b1;
      bus_if.read_n     = 1'b0;
      @(negedge clk);
      bus_if.chipselect = 1'b0;
      bus_if.read_n     = 1'b1;
      d = bus_if.readdata;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_assert = 0;
      n_fail   = 0;
      reset    = 1'b1;
      bus_if.address    = '0;
      bus_if.writedata  = '0;
      bus_if.chipselect = 1'b0;
      bus_if.read_n     = 1'b1;
      bus_if.write_n    = 1'b1;

      repeat (2) @(negedge clk);
      check("rst_out_port", 32'(out_port), 32'h0000_00A5);
      check("rst_readdata", bus_if.readdata, 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      reset = 1'b0;
      @(negedge clk);

      bus_read(ADDR_DATA, rv);
      check("rd_data_reset", rv, 32'h0000_00A5);
      bus_read(ADDR_STATUS, rv);
      check("rd_status_reset", rv, 32'h0);

      bus_write(ADDR_DATA, 32'h0000_000F);
      check("data_wr", 32'(out_port), 32'h0F);
      bus_write(ADDR_SET, 32'h0000_00F0);
      check("outset", 32'(out_port), 32'hFF);
      bus_write(ADDR_CLR, 32'h0000_0003);
      check("outclear", 32'(out_port), 32'hFC);
      bus_read(ADDR_SET, rv);
      check("rd_outset_zero", rv, 32'h0);
      bus_read(ADDR_PULSE, rv);
      check("rd_pulse_zero", rv, 32'h0);
      bus_read(3'd7, rv);
      check("rd_reserved_zero", rv, 32'h0);

      // Basic 3-cycle pulse
      bus_write(ADDR_DATA, 32'h0);
      bus_write(ADDR_LEN, 32'd3);
      bus_write(ADDR_PULSE, 32'h81);
      check("pulse_c1", 32'(out_port), 32'h81);
      @(negedge clk);
      check("pulse_c2", 32'(out_port), 32'h81);
      @(negedge clk);
      check("pulse_c3", 32'(out_port), 32'h81);
      @(negedge clk);
      check("pulse_end", 32'(out_port), 32'h00);
      bus_read(ADDR_STATUS, rv);
      check("pulse_status_done", rv, 32'h4);

      // Overrun while busy, then software clear of overrun and done
      bus_write(ADDR_LEN, 32'd5);
      bus_write(ADDR_PULSE, 32'h01);
      check("ovr_pulse_on", 32'(out_port), 32'h01);
      bus_write(ADDR_PULSE, 32'h02);
      check("ovr_ignored", 32'(out_port), 32'h01);
      bus_read(ADDR_STATUS, rv);
      check("ovr_status_busy", rv, 32'h7);
      bus_write(ADDR_STATUS, 32'h2);
      repeat (2) @(negedge clk);
      check("ovr_pulse_end", 32'(out_port), 32'h00);
      bus_read(ADDR_STATUS, rv);
      check("ovr_cleared", rv, 32'h4);
      bus_read(ADDR_LEN, rv);
      check("len_readback", rv, 32'd5);
      bus_write(ADDR_STATUS, 32'h4);
      bus_read(ADDR_STATUS, rv);
      check("done_cleared", rv, 32'h0);

      // Length 1: second write lands on the final busy cycle
      bus_write(ADDR_LEN, 32'd1);
      bus_write(ADDR_PULSE, 32'h10);
      check("len1_on", 32'(out_port), 32'h10);
      bus_write(ADDR_PULSE, 32'h20);
      check("len1_off", 32'(out_port), 32'h00);
      bus_read(ADDR_STATUS, rv);
      check("len1_last_ovr", rv, 32'h6);
      bus_write(ADDR_STATUS, 32'h6);
      bus_read(ADDR_STATUS, rv);
      check("len1_clear", rv, 32'h0);

      // Done set and clear on the same edge: set wins
      bus_write(ADDR_PULSE, 32'h10);
      bus_write(ADDR_STATUS, 32'h4);
      bus_read(ADDR_STATUS, rv);
      check("done_set_wins", rv, 32'h4);
      bus_write(ADDR_STATUS, 32'h4);

      // Zero length is ignored
      bus_write(ADDR_LEN, 32'd0);
      bus_write(ADDR_PULSE, 32'hFF);
      check("len0_c1", 32'(out_port), 32'h00);
      @(negedge clk);
      check("len0_c2", 32'(out_port), 32'h00);
      bus_read(ADDR_STATUS, rv);
      check("len0_status", rv, 32'h0);

      // Data write during a running pulse
      bus_write(ADDR_LEN, 32'd4);
      bus_write(ADDR_PULSE, 32'h0F);
      bus_write(ADDR_DATA, 32'hF0);
      check("data_in_pulse", 32'(out_port), 32'hFF);
      @(negedge clk);
      check("data_in_pulse_c3", 32'(out_port), 32'hFF);
      repeat (2) @(negedge clk);
      check("data_in_pulse_end", 32'(out_port), 32'hF0);
      bus_write(ADDR_STATUS, 32'h4);

      // Reset asserted mid-pulse
      bus_read(ADDR_DATA, rv);
      check("rd_data_f0", rv, 32'hF0);
      bus_write(ADDR_LEN, 32'd8);
      bus_write(ADDR_PULSE, 32'h0F);
      check("pre_reset_pulse", 32'(out_port), 32'hFF);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("midrst_out_port", 32'(out_port), 32'hA5);
      check("midrst_readdata", bus_if.readdata, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("midrst_out_after", 32'(out_port), 32'hA5);
      bus_read(ADDR_STATUS, rv);
      check("midrst_status", rv, 32'h0);
      bus_read(ADDR_LEN, rv);
      check("midrst_len", rv, 32'h0);

      // Interrupt path
      bus_write(ADDR_IRQMASK, 32'h1);
      bus_read(ADDR_IRQMASK, rv);
`ifdef NIOSMP_PIO_PULSE_IRQ_EN
      check("irqmask_rd", rv, 32'h1);
`else
      check("irqmask_rd", rv, 32'h0);
`endif
      bus_write(ADDR_LEN, 32'd2);
      bus_write(ADDR_PULSE, 32'h01);
      check("irq_pulse_on", 32'(out_port), 32'hA4);
      check("irq_low_busy", 32'(irq), 32'h0);
      repeat (2) @(negedge clk);
      check("irq_pulse_off", 32'(out_port), 32'hA5);
`ifdef NIOSMP_PIO_PULSE_IRQ_EN
      check("irq_done", 32'(irq), 32'h1);
`else
      check("irq_done", 32'(irq), 32'h0);
`endif
      bus_read(ADDR_STATUS, rv);
      check("irq_status", rv, 32'h4);
      bus_write(ADDR_STATUS, 32'h4);
      check("irq_cleared", 32'(irq), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
